interleaver: RTL
================

Name: interleaver

Overview:
- Transmit-side 802.11a block interleaver, the inverse of the receive-side Deinterleaver.
- Sits between the convolutional encoder/puncturer and the symbol mapper.
- Takes a serial coded bit stream, applies the two-step 802.11a permutation per OFDM symbol (NCBPS bits) and emits bits serially.
- Ping-pong buffering allows continuous 1 bit/cycle throughput.

Parameters:
- MAX_NCBPS, 288, bank depth in bits; sized for 64-QAM.
- ADDR_W, 9, bank address width; ceil(log2(MAX_NCBPS)).

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- inputData  in  1  coded bit, sampled when inputValid=1.
- inputValid  in  1  input qualifier.
- mode  in  2  modulation: 0=BPSK (NCBPS 48, NBPSC 1), 1=QPSK (96, 2), 2=16-QAM (192, 4), 3=64-QAM (288, 6).
- outputData  out  1  interleaved bit.
- outputValid  out  1  output qualifier.

Behaviour:
- Reset (reset=0, asynchronous):
  - outputData=0, outputValid=0.
  - Write counter k=0, write bank=0, both bank-full flags cleared, read FSM in IDLE.
  - Reset mid-block discards all partial and buffered data.
- Mode latching:
  - mode is latched into the write-side register on the accepted bit with k=0.
  - mode changes mid-block are ignored.
  - The latched mode travels with the bank as that bank's read-side NCBPS.
- Write side, per accepted bit (inputValid=1):
  - i = (NCBPS/16)*(k mod 16) + floor(k/16).
  - s = max(NBPSC/2, 1).
  - j = s*floor(i/s) + (i + NCBPS - floor(16*i/NCBPS)) mod s.
  - Bit is stored at bank[wbank][j]; k increments.
  - At k = NCBPS-1: set full[wbank], toggle wbank, k returns to 0.
  - inputValid=0: k and bank hold; a partial block waits indefinitely.
- Address generation:
  - Uses incremental counters (k mod 16, floor(k/16), i), not dividers.
  - The mod-s and floor(16*i/NCBPS) terms come from small per-mode counters/compares.
- Read FSM:
  - IDLE -> READ when full[rbank]=1.
  - READ: outputs bank[rbank][r] with outputValid=1, r = 0..NCBPS(rbank)-1, one bit per cycle, no gaps.
  - After the last bit: clear full[rbank], toggle rbank, r=0. Go to READ if full[new rbank]=1, otherwise IDLE.
- Latency: the last input bit of a block is accepted at edge t; the first output bit (j=0) has outputValid=1 after edge t+1.
- Simultaneous events:
  - The write-complete of bank X and the read-complete of bank Y in the same cycle are both honoured.
  - A set and a clear of the same flag in one cycle cannot occur by construction.
- Overflow: not possible at ≤1 input bit/cycle, because a bank takes NCBPS cycles to fill and NCBPS cycles to drain. No backpressure port.
- Output bits are registered; outputData is 0 when outputValid=0.

Optional Feature:
- Macro: INTERLEAVER_BLOCK_START_EN.
- Defined:
  - Adds output port outputFirst (1 bit, reset 0).
  - outputFirst=1 exactly on the cycle carrying output index r=0 of each block, 0 otherwise.
  - Used by the mapper for symbol alignment.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package interleaver_pkg:
  - mode encodings (MODE_BPSK..MODE_64QAM).
  - per-mode NCBPS, NBPSC and s constants/lookup function.
  - MAX_NCBPS.
  - Shared with the Deinterleaver.
- Sub-module interleaver_addr_gen:
  - Inputs: clock, reset, advance, latched mode.
  - Output: write address j for the current k, plus a last-bit flag.
  - Isolates the permutation arithmetic so it can be unit-tested against a reference model.
- Top level holds the two banks, the flags, the write control and the read FSM.

Test Plan:
- BPSK impulse: mode=0; 48 bits, all 0 except k=1 -> one block of 48 outputs, only index 3 =1; first outputValid one cycle after the 48th input.
- 16-QAM impulse: mode=2; 192 bits with k=1 set -> only output index 13 =1.
- 64-QAM impulses: mode=3; two back-to-back 288-bit blocks, block0 k=1 set, block1 k=16 set -> block0 output index 20 =1, block1 index 1 =1; 576 outputs with outputValid continuously high after the first block fills.
- Gapped input: mode=1; 96 bits with inputValid toggling 1/0 -> output identical to the gapless run; 96 contiguous valid outputs.
- Mode change mid-block: mode=3 at k=0, switch to 0 at k=100 -> block is still 288 bits with 64-QAM permutation; next block uses mode 0.
- Reset mid-read: assert reset during output of bit 50 -> outputValid=0 immediately (asynchronous); after release, the next full block (mode=0, 48 bits) outputs correctly with no stale data.

Source files
------------

// File: rtl/interleaver_pkg.sv
// Shared 802.11a interleaver/deinterleaver definitions: mode encodings and per-mode constants.
package interleaver_pkg;
    localparam int MAX_NCBPS = 288;
    localparam int ADDR_W    = 9;

    typedef enum logic [1:0] {
        MODE_BPSK  = 2'd0,
        MODE_QPSK  = 2'd1,
        MODE_16QAM = 2'd2,
        MODE_64QAM = 2'd3
    } mode_t;

    function automatic logic [ADDR_W-1:0] ncbpsOf(input logic [1:0] m);
        case (m)
            MODE_BPSK:  ncbpsOf = 9'd48;
            MODE_QPSK:  ncbpsOf = 9'd96;
            MODE_16QAM: ncbpsOf = 9'd192;
            default:    ncbpsOf = 9'd288;
        endcase
    endfunction

    function automatic logic [2:0] nbpscOf(input logic [1:0] m);
        case (m)
            MODE_BPSK:  nbpscOf = 3'd1;
            MODE_QPSK:  nbpscOf = 3'd2;
            MODE_16QAM: nbpscOf = 3'd4;
            default:    nbpscOf = 3'd6;
        endcase
    endfunction

    // s = max(NBPSC/2, 1)
    function automatic logic [1:0] sOf(input logic [1:0] m);
        case (m)
            MODE_16QAM: sOf = 2'd2;
            MODE_64QAM: sOf = 2'd3;
            default:    sOf = 2'd1;
        endcase
    endfunction

    // NCBPS/16: distance in i between consecutive k within a row of 16
    function automatic logic [4:0] colStepOf(input logic [1:0] m);
        case (m)
            MODE_BPSK:  colStepOf = 5'd3;
            MODE_QPSK:  colStepOf = 5'd6;
            MODE_16QAM: colStepOf = 5'd12;
            default:    colStepOf = 5'd18;
        endcase
    endfunction
endpackage

// File: rtl/interleaver_addr_gen.sv
// Incremental 802.11a write-address generator: j for the current k, plus block start/last flags.
module interleaver_addr_gen #(
    parameter int ADDR_W = interleaver_pkg::ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              advance,
    input  logic [1:0]        mode,
    output logic [ADDR_W-1:0] addr,
    output logic              last,
    output logic              start
);
    import interleaver_pkg::*;

    logic [3:0]        col;      // k mod 16, which is also floor(16*i/NCBPS)
    logic [4:0]        row;      // floor(k/16)
    logic [ADDR_W-1:0] idx;      // i
    logic [1:0]        rowModS;  // i mod s (NCBPS/16 is a multiple of s, so it is row mod s)
    logic [1:0]        colModS;
    logic [1:0]        s;
    logic [4:0]        step;
    logic [1:0]        rot;

    assign s     = sOf(mode);
    assign step  = colStepOf(mode);
    assign last  = (col == 4'd15) && (row == step - 5'd1);
    assign start = (col == 4'd0) && (row == 5'd0);

    // (i + NCBPS - col) mod s, with NCBPS a multiple of s
    always_comb begin
        rot = rowModS - colModS;
        if (rowModS < colModS) rot = rowModS + s - colModS;
    end

    assign addr = idx - ADDR_W'(rowModS) + ADDR_W'(rot);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            col     <= '0;
            row     <= '0;
            idx     <= '0;
            rowModS <= '0;
            colModS <= '0;
        end else if (advance) begin
            if (last) begin
                col     <= '0;
                row     <= '0;
                idx     <= '0;
                rowModS <= '0;
                colModS <= '0;
            end else if (col == 4'd15) begin
                col     <= '0;
                row     <= row + 5'd1;
                idx     <= ADDR_W'(row + 5'd1);
                rowModS <= (rowModS == s - 2'd1) ? 2'd0 : rowModS + 2'd1;
                colModS <= '0;
            end else begin
                col     <= col + 4'd1;
                idx     <= idx + ADDR_W'(step);
                colModS <= (colModS == s - 2'd1) ? 2'd0 : colModS + 2'd1;
            end
        end
    end
endmodule

// File: rtl/interleaver.sv
// 802.11a transmit block interleaver with ping-pong banks, 1 bit/cycle in and out.
// Optional INTERLEAVER_BLOCK_START_EN adds outputFirst marking output index 0 of each block.
module interleaver #(
    parameter int MAX_NCBPS = interleaver_pkg::MAX_NCBPS,
    parameter int ADDR_W    = interleaver_pkg::ADDR_W
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       inputData,
    input  logic       inputValid,
    input  logic [1:0] mode,
`ifdef INTERLEAVER_BLOCK_START_EN
    output logic       outputFirst,
`endif
    output logic       outputData,
    output logic       outputValid
);
    import interleaver_pkg::*;

    typedef enum logic {IDLE, READ} rdState_t;

    logic [1:0][MAX_NCBPS-1:0] bank;
    logic [1:0][1:0]           bankMode;
    logic [1:0]                full;
    logic                      wrBank, rdBank, nxtBank;
    logic [1:0]                wrMode, effMode;
    logic [ADDR_W-1:0]         wrAddr, rdIdx;
    logic                      wrLast, wrStart;
    rdState_t                  state;

    // The mode on the first bit of a block governs that bit's step as well.
    assign effMode = wrStart ? mode : wrMode;
    assign nxtBank = ~rdBank;

    interleaver_addr_gen #(.ADDR_W(ADDR_W)) uAddrGen (
        .clock  (clock),
        .reset  (reset),
        .advance(inputValid),
        .mode   (effMode),
        .addr   (wrAddr),
        .last   (wrLast),
        .start  (wrStart)
    );

    always_ff @(posedge clock) begin
        if (inputValid) bank[wrBank][wrAddr] <= inputData;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wrBank      <= 1'b0;
            wrMode      <= MODE_BPSK;
            bankMode    <= '0;
            full        <= '0;
            rdBank      <= 1'b0;
            rdIdx       <= '0;
            state       <= IDLE;
            outputData  <= 1'b0;
            outputValid <= 1'b0;
`ifdef INTERLEAVER_BLOCK_START_EN
            outputFirst <= 1'b0;
`endif
        end else begin
            if (inputValid) begin
                if (wrStart) begin
                    wrMode           <= mode;
                    bankMode[wrBank] <= mode;
                end
                if (wrLast) begin
                    full[wrBank] <= 1'b1;
                    wrBank       <= ~wrBank;
                end
            end

            case (state)
                IDLE: begin
                    if (full[rdBank]) begin
                        outputData  <= bank[rdBank][0];
                        outputValid <= 1'b1;
                        rdIdx       <= ADDR_W'(1);
                        state       <= READ;
                    end else begin
                        outputData  <= 1'b0;
                        outputValid <= 1'b0;
                    end
`ifdef INTERLEAVER_BLOCK_START_EN
                    outputFirst <= full[rdBank];
`endif
                end
                READ: begin
                    if (rdIdx == ADDR_W'(ncbpsOf(bankMode[rdBank]))) begin
                        // Last bit went out on the previous edge; chain straight into the other bank.
                        full[rdBank] <= 1'b0;
                        rdBank       <= nxtBank;
                        if (full[nxtBank]) begin
                            outputData  <= bank[nxtBank][0];
                            outputValid <= 1'b1;
                            rdIdx       <= ADDR_W'(1);
                        end else begin
                            outputData  <= 1'b0;
                            outputValid <= 1'b0;
                            rdIdx       <= '0;
                            state       <= IDLE;
                        end
`ifdef INTERLEAVER_BLOCK_START_EN
                        outputFirst <= full[nxtBank];
`endif
                    end else begin
                        outputData  <= bank[rdBank][rdIdx];
                        outputValid <= 1'b1;
                        rdIdx       <= rdIdx + ADDR_W'(1);
`ifdef INTERLEAVER_BLOCK_START_EN
                        outputFirst <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
